uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that lets several producers share the single TX FIFO write port of the `uart` block. It grants one requester at a time and holds the grant for a whole message, ending at the requester's `last` byte or at a length cap, so messages never interleave on the serial line. It sits between the producer modules and `uart` (`i_tx_data`, `i_tx_req`, `o_tx_rdy`).

## Interface
Parameters:
- `NumReq`, 4: number of requesters (2..8).
- `DataLength`, 8: byte width; must match `uart`.
- `MaxBytes`, 16: maximum data bytes per grant (≥2).
- `HeaderBase`, 8'hA0: header byte base; used only with `UART_ARB_HDR_EN`.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_req`  in  NumReq  requester r has a byte valid.
- `i_data`  in  NumReq*DataLength  byte of requester r at `[r*DataLength +: DataLength]`.
- `i_last`  in  NumReq  byte of requester r is the final byte of its message.
- `o_ack`  out  NumReq  one-hot; the byte of requester r is consumed this cycle.
- `o_grant`  out  NumReq  one-hot registered grant, or all zero.
- `o_busy`  out  1  a grant is active (state ≠ IDLE).
- `o_trunc`  out  1  one-cycle pulse when a grant is cut at `MaxBytes`.
- `o_tx_data`  out  DataLength  to `uart.i_tx_data`.
- `o_tx_req`  out  1  to `uart.i_tx_req`; a byte is written at every rising edge where this is 1.
- `i_tx_rdy`  in  1  from `uart.o_tx_rdy` (TX FIFO not full).

## Operation
- States: IDLE, HDR (present only with the macro), DATA.
- IDLE: if `|i_req`, choose the first asserted requester searching from `ptr+1` modulo NumReq. Register it into `o_grant` and a byte counter is cleared (`cnt=0`). Next state is HDR if the macro is defined, otherwise DATA.
- HDR:
  - `o_tx_data = HeaderBase | g`.
  - `o_tx_req = i_tx_rdy`.
  - On transfer, go to DATA. No `o_ack` is issued.
- DATA:
  - `o_tx_data = i_data[g]`.
  - `o_tx_req = i_req[g] & i_tx_rdy`.
  - `o_ack[g] = o_tx_req`.
  - On transfer, `cnt++`.
  - If `i_last[g]` is set on the transferred byte: go to IDLE and set `ptr<=g`.
  - Else if `cnt==MaxBytes-1` (that is, the `MaxBytes`-th byte was just sent): pulse `o_trunc`, go to IDLE, set `ptr<=g`.
- `i_req[g]` dropping mid-message does not release the grant. The arbiter waits in DATA indefinitely.
- `i_req` of non-granted requesters is ignored. Their `o_ack` bits stay 0.
- `o_tx_req`, `o_tx_data` and `o_ack` are combinational from the state and inputs. `o_tx_data` is don't-care while `o_tx_req=0`; it is driven 0 in IDLE.
- The counter is `$clog2(MaxBytes)` bits wide and never wraps; the cap check precedes any overflow.

## Timing
- Reset values:
  - state = IDLE
  - `o_grant = 0`, `o_busy = 0`, `o_trunc = 0`, `o_tx_req = 0`, `o_ack = 0`, `o_tx_data = 0`
  - `ptr = NumReq-1`, so requester 0 has the highest priority after reset.
  - `cnt = 0`
- Grant latency: with `i_req` seen in IDLE at cycle 0, the grant is visible at cycle 1.
  - Without the macro, the first data byte can transfer at the cycle-1 edge.
  - With the macro, the header transfers at cycle 1 and data at cycle 2 or later.
- Throughput: one byte per cycle while `i_tx_rdy=1` and `i_req[g]=1`.
- Message gap: exactly one IDLE cycle between the last byte of one grant and the first transfer of the next grant.
- `i_tx_rdy=0` stalls the transfer. There is no byte loss, and `o_ack` stays 0 until the transfer happens.
- Reset asserted mid-message returns the block to IDLE at the next edge. A partial message is abandoned, with no stop or trailer inserted.
- Simultaneous requests in IDLE resolve purely by round-robin from `ptr+1`.

## Configuration
- `UART_ARB_HDR_EN` defined:
  - The HDR state exists, and every grant emits one header byte `HeaderBase | id` before the data.
  - The header does not count toward `MaxBytes`.
- `UART_ARB_HDR_EN` undefined:
  - There is no HDR state, and IDLE goes directly to DATA.
  - `HeaderBase` is unused.

## Test plan
- Reset, then `i_req=4'b0001` with a 3-byte message `11,22,33` (`last` on `33`) and `i_tx_rdy=1`. Required response:
  - grant `0001` at cycle 1;
  - without the macro: bytes at cycles 1, 2, 3, then `o_busy=0` at cycle 4;
  - with the macro: an `A0` byte first.
- `i_req=4'b1111` held, each requester sending 1-byte messages. Required grant order after reset: 0, 1, 2, 3, 0. Each message is separated by exactly one IDLE cycle.
- Requester 2 sends a 5-byte message while requester 1 requests from the second cycle onward. All 5 bytes of requester 2 come out contiguously before any byte of requester 1, and `ptr=2` afterwards, so requester 3 is checked before requester 1.
- With `MaxBytes=16`, requester 0 streams without `last`. Required response:
  - 16 bytes are transferred;
  - `o_trunc` pulses one cycle on the 16th byte;
  - `o_ack` is 0 afterwards until regrant.
- Requester 0 is granted and `i_tx_rdy` is toggled 1,0,0,1 against the 3-byte message `11,22,33`. `o_ack` and `o_tx_req` are asserted only when `i_tx_rdy=1`, and the byte order is preserved: `11,22,33`.
- Assert `i_rst` after 2 of 4 bytes of requester 3. At the next edge all outputs are 0, and a subsequent request from 3 and 0 together grants 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart TX FIFO write port between message producers.
// Optional per-grant header byte (HeaderBase | id) is enabled by defining UART_ARB_HDR_EN.
module uart_tx_arbiter #(
    parameter int                    NumReq     = 4,
    parameter int                    DataLength = 8,
    parameter int                    MaxBytes   = 16,
    parameter logic [DataLength-1:0] HeaderBase = 8'hA0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NumReq-1:0]            i_req,
    input  logic [NumReq*DataLength-1:0] i_data,
    input  logic [NumReq-1:0]            i_last,
    output logic [NumReq-1:0]            o_ack,
    output logic [NumReq-1:0]            o_grant,
    output logic                         o_busy,
    output logic                         o_trunc,
    output logic [DataLength-1:0]        o_tx_data,
    output logic                         o_tx_req,
    input  logic                         i_tx_rdy
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = $clog2(MaxBytes);
    localparam logic [CntW-1:0]   CntCap  = CntW'(MaxBytes - 1);
    localparam logic [IdxW-1:0]   PtrRst  = IdxW'(NumReq - 1);
    localparam logic [NumReq-1:0] OneHot0 = {{(NumReq-1){1'b0}}, 1'b1};

`ifdef UART_ARB_HDR_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd2
    } state_t;
`endif

    state_t              r_state;
    logic [NumReq-1:0]   r_grant;
    logic [IdxW-1:0]     r_gidx;
    logic [IdxW-1:0]     r_ptr;
    logic [CntW-1:0]     r_cnt;

    state_t              w_state_nxt;
    logic [NumReq-1:0]   w_grant_nxt;
    logic [IdxW-1:0]     w_gidx_nxt;
    logic [IdxW-1:0]     w_ptr_nxt;
    logic [CntW-1:0]     w_cnt_nxt;
    logic                w_pick_vld;
    logic [IdxW-1:0]     w_pick_idx;
    logic                w_tx_req;
    logic [DataLength-1:0] w_tx_data;
    logic [NumReq-1:0]   w_ack;
    logic                w_trunc;
    int                  w_cand;

    // Round-robin pick: first asserted request searching upward from ptr+1.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_cand     = 0;
        for (int i = 1; i <= NumReq; i++) begin
            w_cand = (int'(r_ptr) + i) % NumReq;
            if (!w_pick_vld && i_req[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand[IdxW-1:0];
            end else begin
                w_pick_vld = w_pick_vld;
            end
        end
    end

    // Next-state logic and combinational write-port outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_tx_req    = 1'b0;
        w_tx_data   = '0;
        w_ack       = '0;
        w_trunc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nxt = OneHot0 << w_pick_idx;
                    w_gidx_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
`ifdef UART_ARB_HDR_EN
                    w_state_nxt = HDR;
`else
                    w_state_nxt = DATA;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                w_tx_data = HeaderBase | DataLength'(r_gidx);
                w_tx_req  = i_tx_rdy;
                if (i_tx_rdy) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = HDR;
                end
            end
`endif
            DATA: begin
                w_tx_data = i_data[r_gidx*DataLength +: DataLength];
                w_tx_req  = i_req[r_gidx] & i_tx_rdy;
                w_ack     = w_tx_req ? r_grant : '0;
                if (w_tx_req) begin
                    // Cap test comes before the increment so the counter never wraps.
                    if (i_last[r_gidx]) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = r_gidx;
                    end else if (r_cnt == CntCap) begin
                        w_trunc     = 1'b1;
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = r_gidx;
                    end else begin
                        w_cnt_nxt   = r_cnt + CntW'(1);
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, grant, round-robin pointer and byte counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= PtrRst;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_grant   = r_grant;
    assign o_busy    = (r_state != IDLE);
    assign o_trunc   = w_trunc;
    assign o_tx_req  = w_tx_req;
    assign o_tx_data = w_tx_data;
    assign o_ack     = w_ack;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default build, header disabled).
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        trunc;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        rdy;
    int          pass_cnt = 0;
    int          tot_cnt  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumReq(4), .DataLength(8), .MaxBytes(16), .HeaderBase(8'hA0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_last(last),
        .o_ack(ack), .o_grant(grant), .o_busy(busy), .o_trunc(trunc),
        .o_tx_data(tx_data), .o_tx_req(tx_req), .i_tx_rdy(rdy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int r, input logic [7:0] v);
        data[r*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; last = 4'b0000; data = 32'h0; rdy = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; last = 4'b1111; data = 32'hFFFF_FFFF; rdy = 1'b1;
        step();
        step();
        #1;
        tot_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); else pass_cnt++;
        tot_cnt++; if (trunc !== 1'b0) $display("FAIL reset_trunc got=%b exp=%b", trunc, 1'b0); else pass_cnt++;
        tot_cnt++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req got=%b exp=%b", tx_req, 1'b0); else pass_cnt++;
        tot_cnt++; if (ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0000); else pass_cnt++;
        tot_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=%h", tx_data, 8'h00); else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0001; set_byte(0, 8'h11); last = 4'b0000; rdy = 1'b1;
        #1;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got=%b exp=%b", busy, 1'b0); else pass_cnt++;
        step();
        #1;
        tot_cnt++; if (grant !== 4'b0001) $display("FAIL basic_grant got=%b exp=%b", grant, 4'b0001); else pass_cnt++;
        tot_cnt++; if (tx_req !== 1'b1) $display("FAIL basic_tx_req1 got=%b exp=%b", tx_req, 1'b1); else pass_cnt++;
        tot_cnt++; if (tx_data !== 8'h11) $display("FAIL basic_byte1 got=%h exp=%h", tx_data, 8'h11); else pass_cnt++;
        tot_cnt++; if (ack !== 4'b0001) $display("FAIL basic_ack1 got=%b exp=%b", ack, 4'b0001); else pass_cnt++;
        step();
        set_byte(0, 8'h22);
        #1;
        tot_cnt++; if (tx_data !== 8'h22) $display("FAIL basic_byte2 got=%h exp=%h", tx_data, 8'h22); else pass_cnt++;
        tot_cnt++; if (ack !== 4'b0001) $display("FAIL basic_ack2 got=%b exp=%b", ack, 4'b0001); else pass_cnt++;
        step();
        set_byte(0, 8'h33); last = 4'b0001;
        #1;
        tot_cnt++; if (tx_data !== 8'h33) $display("FAIL basic_byte3 got=%h exp=%h", tx_data, 8'h33); else pass_cnt++;
        tot_cnt++; if (tx_req !== 1'b1) $display("FAIL basic_tx_req3 got=%b exp=%b", tx_req, 1'b1); else pass_cnt++;
        step();
        req = 4'b0000; last = 4'b0000;
        #1;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL basic_done_busy got=%b exp=%b", busy, 1'b0); else pass_cnt++;
        tot_cnt++; if (grant !== 4'b0000) $display("FAIL basic_done_grant got=%b exp=%b", grant, 4'b0000); else pass_cnt++;
        tot_cnt++; if (tx_data !== 8'h00) $display("FAIL basic_idle_data got=%h exp=%h", tx_data, 8'h00); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] eb;
        do_reset();
        req = 4'b1111; last = 4'b1111; rdy = 1'b1;
        for (int r = 0; r < 4; r++) set_byte(r, 8'h10 + 8'(r));
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            eb = 8'h10 + 8'(k % 4);
            #1;
            tot_cnt++; if (busy !== 1'b0) $display("FAIL rr_gap%0d got=%b exp=%b", k, busy, 1'b0); else pass_cnt++;
            step();
            #1;
            tot_cnt++; if (grant !== eg) $display("FAIL rr_grant%0d got=%b exp=%b", k, grant, eg); else pass_cnt++;
            tot_cnt++; if (tx_data !== eb) $display("FAIL rr_byte%0d got=%h exp=%h", k, tx_data, eb); else pass_cnt++;
            tot_cnt++; if (ack !== eg) $display("FAIL rr_ack%0d got=%b exp=%b", k, ack, eg); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_hold();
        logic [7:0] eb;
        do_reset();
        req = 4'b0100; last = 4'b0000; rdy = 1'b1; set_byte(2, 8'h30);
        step();
        req = 4'b0110; set_byte(1, 8'hEE); last[1] = 1'b1;
        for (int b = 0; b < 5; b++) begin
            eb = 8'h30 + 8'(b);
            set_byte(2, eb);
            last[2] = (b == 4);
            #1;
            tot_cnt++; if (grant !== 4'b0100) $display("FAIL hold_grant%0d got=%b exp=%b", b, grant, 4'b0100); else pass_cnt++;
            tot_cnt++; if (ack !== 4'b0100) $display("FAIL hold_ack%0d got=%b exp=%b", b, ack, 4'b0100); else pass_cnt++;
            tot_cnt++; if (tx_data !== eb) $display("FAIL hold_byte%0d got=%h exp=%h", b, tx_data, eb); else pass_cnt++;
            step();
        end
        req = 4'b1010; last = 4'b1010; set_byte(3, 8'h3F);
        #1;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL hold_gap got=%b exp=%b", busy, 1'b0); else pass_cnt++;
        step();
        #1;
        tot_cnt++; if (grant !== 4'b1000) $display("FAIL hold_next_grant got=%b exp=%b", grant, 4'b1000); else pass_cnt++;
    endtask

    task automatic test_trunc();
        do_reset();
        req = 4'b0001; last = 4'b0000; rdy = 1'b1; set_byte(0, 8'h00);
        step();
        for (int k = 0; k < 16; k++) begin
            set_byte(0, 8'(k));
            #1;
            tot_cnt++; if (tx_data !== 8'(k)) $display("FAIL trunc_byte%0d got=%h exp=%h", k, tx_data, 8'(k)); else pass_cnt++;
            tot_cnt++; if (ack !== 4'b0001) $display("FAIL trunc_ack%0d got=%b exp=%b", k, ack, 4'b0001); else pass_cnt++;
            tot_cnt++; if (trunc !== (k == 15)) $display("FAIL trunc_pulse%0d got=%b exp=%b", k, trunc, (k == 15)); else pass_cnt++;
            step();
        end
        #1;
        tot_cnt++; if (ack !== 4'b0000) $display("FAIL trunc_after_ack got=%b exp=%b", ack, 4'b0000); else pass_cnt++;
        tot_cnt++; if (trunc !== 1'b0) $display("FAIL trunc_after_pulse got=%b exp=%b", trunc, 1'b0); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL trunc_after_busy got=%b exp=%b", busy, 1'b0); else pass_cnt++;
        step();
        #1;
        tot_cnt++; if (ack !== 4'b0001) $display("FAIL trunc_regrant_ack got=%b exp=%b", ack, 4'b0001); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [7:0] msg [3];
        logic       pat [5];
        int         idx;
        msg[0] = 8'h11; msg[1] = 8'h22; msg[2] = 8'h33;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        idx = 0;
        do_reset();
        req = 4'b0001; last = 4'b0000; rdy = 1'b1; set_byte(0, msg[0]);
        step();
        for (int c = 0; c < 5; c++) begin
            set_byte(0, msg[idx]);
            last = (idx == 2) ? 4'b0001 : 4'b0000;
            rdy = pat[c];
            #1;
            tot_cnt++; if (tx_req !== pat[c]) $display("FAIL stall_req%0d got=%b exp=%b", c, tx_req, pat[c]); else pass_cnt++;
            tot_cnt++; if (ack !== (pat[c] ? 4'b0001 : 4'b0000)) $display("FAIL stall_ack%0d got=%b exp=%b", c, ack, (pat[c] ? 4'b0001 : 4'b0000)); else pass_cnt++;
            if (pat[c]) begin
                tot_cnt++; if (tx_data !== msg[idx]) $display("FAIL stall_byte%0d got=%h exp=%h", c, tx_data, msg[idx]); else pass_cnt++;
                idx++;
            end
            step();
        end
        req = 4'b0000; last = 4'b0000; rdy = 1'b1;
        #1;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL stall_done got=%b exp=%b", busy, 1'b0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000; last = 4'b0000; rdy = 1'b1; set_byte(3, 8'h40);
        step();
        for (int b = 0; b < 2; b++) begin
            set_byte(3, 8'h40 + 8'(b));
            #1;
            tot_cnt++; if (tx_data !== 8'h40 + 8'(b)) $display("FAIL rstmid_byte%0d got=%h exp=%h", b, tx_data, 8'h40 + 8'(b)); else pass_cnt++;
            step();
        end
        set_byte(3, 8'h42);
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b1001; set_byte(0, 8'h50);
        #1;
        tot_cnt++; if (grant !== 4'b0000) $display("FAIL rstmid_grant got=%b exp=%b", grant, 4'b0000); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=%b", busy, 1'b0); else pass_cnt++;
        tot_cnt++; if (tx_req !== 1'b0) $display("FAIL rstmid_tx_req got=%b exp=%b", tx_req, 1'b0); else pass_cnt++;
        tot_cnt++; if (ack !== 4'b0000) $display("FAIL rstmid_ack got=%b exp=%b", ack, 4'b0000); else pass_cnt++;
        tot_cnt++; if (tx_data !== 8'h00) $display("FAIL rstmid_tx_data got=%h exp=%h", tx_data, 8'h00); else pass_cnt++;
        tot_cnt++; if (trunc !== 1'b0) $display("FAIL rstmid_trunc got=%b exp=%b", trunc, 1'b0); else pass_cnt++;
        step();
        #1;
        tot_cnt++; if (grant !== 4'b0001) $display("FAIL rstmid_regrant got=%b exp=%b", grant, 4'b0001); else pass_cnt++;
        tot_cnt++; if (tx_data !== 8'h50) $display("FAIL rstmid_rebyte got=%h exp=%h", tx_data, 8'h50); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_hold();
        test_trunc();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
